// File: rtl/ls299_pkg.sv
// Shared definitions for the LS299 universal shift/storage register.
package ls299_pkg;

  // Mode select encoding, formed as {S1, S0}
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } ls299_mode_e;

  localparam int unsigned LS299_W = 8;

  // The bus is driven only with both enables low and outside load mode.
  // In load mode the bus must stay free for an external driver.
  function automatic logic ls299_drive_en(input logic ng1, input logic ng2,
                                          input logic s1, input logic s0);
    return !ng1 && !ng2 && !(s1 && s0);
  endfunction

endpackage

// File: rtl/ls299.sv
// LS299: 8-bit universal shift/storage register.
// The register is cleared asynchronously and has three-state bus I/O.
// This is a zero-delay functional model. IO[0] is A and IO[7] is H.
module ls299
  import ls299_pkg::*;
(
  input  logic       CLK,
  input  logic       nCLR,
  input  logic       S0,
  input  logic       S1,
  input  logic       nG1,
  input  logic       nG2,
  input  logic       SR,
  input  logic       SL,
  inout  wire  [7:0] IO,
  output logic       QA_S,
  output logic       QH_S
);

  logic [LS299_W-1:0] q_q;
  logic [LS299_W-1:0] q_d;
  logic               oe;

  // Next-state selection from the mode bits sampled at the clock edge.
  // An X/Z mode falls through to the default branch and poisons Q in simulation.
  always_comb begin
    q_d = q_q;
    case ({S1, S0})
      MODE_HOLD: q_d = q_q;
      MODE_SHR:  q_d = {q_q[6:0], SR};
      MODE_SHL:  q_d = {SL, q_q[7:1]};
      MODE_LOAD: q_d = IO;
      default:   q_d = 'x;
    endcase
  end

  // State register. An active clear wins over a coincident clock edge.
  always_ff @(posedge CLK or negedge nCLR) begin
    if (!nCLR) q_q <= '0;
    else       q_q <= q_d;
  end

  assign oe   = ls299_drive_en(nG1, nG2, S1, S0);
  assign IO   = oe ? q_q : 'z;
  assign QA_S = q_q[0];
  assign QH_S = q_q[7];

endmodule

// File: tb/tb_ls299.sv
// Directed self-checking bench for ls299.
module tb_ls299;

  logic       CLK = 1'b0;
  logic       nCLR;
  logic       S0, S1, nG1, nG2, SR, SL;
  wire  [7:0] IO;
  logic       QA_S, QH_S;
  logic [7:0] io_drv;
  logic       io_en;

  int total = 0;
  int bad   = 0;

  logic [7:0] seq_c3;

  assign IO = io_en ? io_drv : 8'bz;

  ls299 dut (
    .CLK  (CLK),
    .nCLR (nCLR),
    .S0   (S0),
    .S1   (S1),
    .nG1  (nG1),
    .nG2  (nG2),
    .SR   (SR),
    .SL   (SL),
    .IO   (IO),
    .QA_S (QA_S),
    .QH_S (QH_S)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    {S1, S0} = m;
  endtask

  // Load a value through the bus, then return to hold with the bus released
  task automatic load(input logic [7:0] v);
    set_mode(2'b11);
    io_drv = v;
    io_en  = 1'b1;
    tick();
    set_mode(2'b00);
    io_en  = 1'b0;
    #1;
  endtask

  initial begin
    nCLR = 1'b0; S0 = 1'b0; S1 = 1'b0; nG1 = 1'b0; nG2 = 1'b0;
    SR = 1'b0; SL = 1'b0; io_drv = 8'h00; io_en = 1'b0;
    seq_c3 = 8'hC3;
    #12;
    chk("rst_io", IO, 8'h00);
    chk("rst_qa", {7'd0, QA_S}, 8'h00);
    chk("rst_qh", {7'd0, QH_S}, 8'h00);
    nCLR = 1'b1;
    tick();

    // 1: asynchronous clear mid-cycle, then shift right with SR=1
    load(8'hA5);
    chk("t1_load_a5", IO, 8'hA5);
    chk("t1_qa_pre", {7'd0, QA_S}, 8'h01);
    nCLR = 1'b0;
    #1;
    chk("t1_clr_io", IO, 8'h00);
    chk("t1_clr_qa", {7'd0, QA_S}, 8'h00);
    chk("t1_clr_qh", {7'd0, QH_S}, 8'h00);
    nCLR = 1'b1;
    set_mode(2'b01);
    SR = 1'b1;
    tick();
    chk("t1_shr_sr1", IO, 8'h01);
    set_mode(2'b00);
    SR = 1'b0;
    tick();
    chk("t1_hold", IO, 8'h01);

    // 2: parallel load with an external bus driver
    load(8'hC3);
    chk("t2_load_c3", IO, 8'hC3);

    // 3: shift right 8 times, QH_S emits the byte MSB first
    set_mode(2'b01);
    SR = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_qh%0d", i), {7'd0, QH_S}, {7'd0, seq_c3[7-i]});
      tick();
    end
    set_mode(2'b00);
    #1;
    chk("t3_final", IO, 8'h00);

    // 4: shift left 8 times with SL=1, QA_S emits the byte LSB first
    load(8'hC3);
    set_mode(2'b10);
    SL = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_qa%0d", i), {7'd0, QA_S}, {7'd0, seq_c3[i]});
      tick();
    end
    set_mode(2'b00);
    SL = 1'b0;
    #1;
    chk("t4_final", IO, 8'hFF);

    // 5: output enables. A released bus reads the external 00; a driven bus reads Q.
    load(8'h5A);
    io_drv = 8'h00;
    io_en  = 1'b1;
    nG1 = 1'b1; nG2 = 1'b0;
    #1;
    chk("t5_ng1_hi", IO, 8'h00);
    nG1 = 1'b0; nG2 = 1'b1;
    #1;
    chk("t5_ng2_hi", IO, 8'h00);
    nG2 = 1'b0;
    io_en = 1'b0;
    #1;
    chk("t5_both_lo", IO, 8'h5A);
    io_en = 1'b1;
    set_mode(2'b11);
    #1;
    chk("t5_load_rel", IO, 8'h00);
    set_mode(2'b00);
    io_en = 1'b0;
    #1;
    chk("t5_q_kept", IO, 8'h5A);

    // 6: clear coincident with a load edge, then a normal load after release
    set_mode(2'b11);
    io_drv = 8'hFF;
    io_en  = 1'b1;
    @(posedge CLK);
    nCLR = 1'b0;
    #1;
    chk("t6_clr_qa", {7'd0, QA_S}, 8'h00);
    chk("t6_clr_qh", {7'd0, QH_S}, 8'h00);
    set_mode(2'b00);
    io_en = 1'b0;
    #1;
    chk("t6_clr_io", IO, 8'h00);
    @(negedge CLK);
    nCLR = 1'b1;
    set_mode(2'b11);
    io_en = 1'b1;
    tick();
    set_mode(2'b00);
    io_en = 1'b0;
    #1;
    chk("t6_load_ff", IO, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
